// File: rtl/ws_frame_tracker_pkg.sv
// Shared types and limits for the slave-mode word-select frame tracker.
//   fmt_t       : framing format of the incoming ws
//   trk_state_t : tracker state reported to ws_control
package ws_frame_tracker_pkg;

  typedef enum logic [1:0] {
    FMT_I2S = 2'd0,
    FMT_LJ  = 2'd1,
    FMT_TDM = 2'd2
  } fmt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } trk_state_t;

  localparam int DEF_MAX_CH      = 8;
  localparam int DEF_MAX_SLOT_W  = 32;
  localparam int DEF_LOCK_FRAMES = 2;
  localparam int MIN_SLOT_BITS   = 8;
  localparam int STEREO_CH       = 2;

endpackage

// File: rtl/ws_frame_tracker_if.sv
// Configuration / ws input and tracking status bundle for ws_frame_tracker.
//   master : drives en, ws, cfg_*; observes status
//   slave  : the tracker
// Status outputs: state, ch_idx, bit_idx, ch_valid, frame_start, slot_start,
// locked, sync_err.
interface ws_frame_tracker_if #(
  parameter int MAX_CH     = ws_frame_tracker_pkg::DEF_MAX_CH,
  parameter int MAX_SLOT_W = ws_frame_tracker_pkg::DEF_MAX_SLOT_W
);
  logic                               en;
  logic                               ws;
  ws_frame_tracker_pkg::fmt_t         cfg_fmt;
  logic [$clog2(MAX_SLOT_W):0]        cfg_slot_bits;
  logic [$clog2(MAX_CH):0]            cfg_num_ch;
  logic                               cfg_mono;

  ws_frame_tracker_pkg::trk_state_t   state;
  logic [$clog2(MAX_CH)-1:0]          ch_idx;
  logic [$clog2(MAX_SLOT_W)-1:0]      bit_idx;
  logic                               ch_valid;
  logic                               frame_start;
  logic                               slot_start;
  logic                               locked;
  logic                               sync_err;

  modport master (
    output en, ws, cfg_fmt, cfg_slot_bits, cfg_num_ch, cfg_mono,
    input  state, ch_idx, bit_idx, ch_valid, frame_start, slot_start, locked, sync_err
  );

  modport slave (
    input  en, ws, cfg_fmt, cfg_slot_bits, cfg_num_ch, cfg_mono,
    output state, ch_idx, bit_idx, ch_valid, frame_start, slot_start, locked, sync_err
  );
endinterface

// File: rtl/ws_edge_detect.sv
// ws sampler and edge decoder (falling-edge sck domain).
//   clk, rst   : bit clock, async active-high reset
//   ws, fmt    : external word select and framing format
//   frame_edge : ws transition that opens a frame
//   mid_edge   : opposite transition (channel 0 -> 1), I2S/LJ only
module ws_edge_detect
  import ws_frame_tracker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ws,
  input  fmt_t fmt,
  output logic frame_edge,
  output logic mid_edge
);
  logic ws_q, ws_qq;
  logic rise, fall;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ws_q  <= 1'b0;
      ws_qq <= 1'b0;
    end else begin
      ws_q  <= ws;
      ws_qq <= ws_q;
    end
  end

  assign rise = ws_q & ~ws_qq;
  assign fall = ~ws_q & ws_qq;

  // I2S opens the frame on the left channel (ws low); LJ/TDM on ws high.
  assign frame_edge = (fmt == FMT_I2S) ? fall : rise;
  assign mid_edge   = (fmt == FMT_I2S) ? rise :
                      (fmt == FMT_LJ)  ? fall : 1'b0;
endmodule

// File: rtl/ws_frame_tracker.sv
// Slave-mode word-select tracker. Follows an externally driven ws in I2S, LJ
// or TDM framing, reports slot/bit position, verifies frame length, declares
// lock and flags sync errors / loss of ws. All flops on the falling edge.
//   clk, rst : sck, async active-high reset
//   bus      : ws_frame_tracker_if.slave (en, ws, cfg_* in; status out)
module ws_frame_tracker
  import ws_frame_tracker_pkg::*;
#(
  parameter int MAX_CH      = DEF_MAX_CH,
  parameter int MAX_SLOT_W  = DEF_MAX_SLOT_W,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic clk,
  input  logic rst,
  ws_frame_tracker_if.slave bus
);
  localparam int CH_W   = $clog2(MAX_CH);
  localparam int BIT_W  = $clog2(MAX_SLOT_W);
  localparam int FCNT_W = $clog2(MAX_CH * MAX_SLOT_W) + 1;
  localparam int LEN_W  = FCNT_W + 1;  // room for frame_len + one slot
  localparam int LK_W   = $clog2(LOCK_FRAMES + 1);

  logic frame_edge, mid_edge;

  ws_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .ws         (bus.ws),
    .fmt        (bus.cfg_fmt),
    .frame_edge (frame_edge),
    .mid_edge   (mid_edge)
  );

  trk_state_t        st_q, st_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [LK_W-1:0]   lk_q, lk_d;
  logic              locked_q, locked_d;
  logic              fs_q, fs_d, ss_q, ss_d, err_q, err_d, cv_q, cv_d;

  logic             tdm, last_bit;
  logic [LEN_W-1:0] slot_bits, nch, frame_len, timeout, fcnt_x;

  assign tdm       = (bus.cfg_fmt == FMT_TDM);
  assign slot_bits = LEN_W'(bus.cfg_slot_bits);
  assign nch       = tdm ? LEN_W'(bus.cfg_num_ch) : LEN_W'(STEREO_CH);
  assign frame_len = nch * slot_bits;
  assign timeout   = frame_len + slot_bits;
  assign fcnt_x    = LEN_W'(fcnt_q);
  assign last_bit  = (LEN_W'(bit_q) + 1'b1) == slot_bits;

  always_comb begin
    st_d     = st_q;
    ch_d     = ch_q;
    bit_d    = bit_q;
    fcnt_d   = fcnt_q;
    lk_d     = lk_q;
    locked_d = locked_q;
    fs_d     = 1'b0;
    ss_d     = 1'b0;
    err_d    = 1'b0;

    if (!bus.en) begin
      st_d     = IDLE;
      ch_d     = '0;
      bit_d    = '0;
      fcnt_d   = '0;
      lk_d     = '0;
      locked_d = 1'b0;
    end else if (st_q == IDLE) begin
      ch_d   = '0;
      bit_d  = '0;
      fcnt_d = '0;
      if (frame_edge) begin
        st_d   = ACQUIRE;
        fs_d   = 1'b1;
        ss_d   = 1'b1;
        fcnt_d = FCNT_W'(1);
      end
    end else if (frame_edge) begin
      // Frame edge wins over timeout: a late edge is a length error, not loss.
      ch_d   = '0;
      bit_d  = '0;
      fcnt_d = FCNT_W'(1);
      fs_d   = 1'b1;
      ss_d   = 1'b1;
      if (fcnt_x == frame_len) begin
        if (lk_q != LK_W'(LOCK_FRAMES)) lk_d = lk_q + 1'b1;
        if (lk_d == LK_W'(LOCK_FRAMES)) begin
          st_d     = LOCKED;
          locked_d = 1'b1;
        end
      end else begin
        err_d    = 1'b1;
        lk_d     = '0;
        locked_d = 1'b0;
        st_d     = ACQUIRE;
      end
    end else if (mid_edge) begin
      ch_d   = CH_W'(1);
      bit_d  = '0;
      ss_d   = 1'b1;
      fcnt_d = fcnt_q + 1'b1;
      if (fcnt_x != slot_bits) begin
        // Trust the misplaced edge: realign to the start of slot 1.
        err_d    = 1'b1;
        lk_d     = '0;
        locked_d = 1'b0;
        st_d     = ACQUIRE;
        fcnt_d   = FCNT_W'(slot_bits) + 1'b1;
      end
    end else if (fcnt_x >= timeout) begin
      err_d    = 1'b1;
      st_d     = IDLE;
      ch_d     = '0;
      bit_d    = '0;
      fcnt_d   = '0;
      lk_d     = '0;
      locked_d = 1'b0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
      if (last_bit) begin
        bit_d = '0;
        // Saturate so an overrun with MAX_CH slots cannot alias slot 0.
        if (ch_q != CH_W'(MAX_CH - 1)) ch_d = ch_q + 1'b1;
        ss_d = tdm;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end

    // Bits past the expected frame end (waiting for a late edge) carry no data.
    cv_d = (st_d != IDLE) &&
           (LEN_W'(ch_d) < nch) &&
           (LEN_W'(fcnt_d) <= frame_len) &&
           !(!tdm && bus.cfg_mono && (ch_d == CH_W'(1)));
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      ch_q     <= '0;
      bit_q    <= '0;
      fcnt_q   <= '0;
      lk_q     <= '0;
      locked_q <= 1'b0;
      fs_q     <= 1'b0;
      ss_q     <= 1'b0;
      err_q    <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      ch_q     <= ch_d;
      bit_q    <= bit_d;
      fcnt_q   <= fcnt_d;
      lk_q     <= lk_d;
      locked_q <= locked_d;
      fs_q     <= fs_d;
      ss_q     <= ss_d;
      err_q    <= err_d;
      cv_q     <= cv_d;
    end
  end

  assign bus.state       = st_q;
  assign bus.ch_idx      = ch_q;
  assign bus.bit_idx     = bit_q;
  assign bus.ch_valid    = cv_q;
  assign bus.frame_start = fs_q;
  assign bus.slot_start  = ss_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = err_q;
endmodule
